// File: rtl/pwm_capture_pkg.sv
// PWM capture shared types and default sizing.
// Imported by the capture top and its edge detector.
package pwm_capture_pkg;

  localparam int DEF_COUNT_W     = 17;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 131071;

  typedef enum logic [1:0] {
    ARM,
    HIGH,
    LOW
  } cap_state_t;

endpackage

// File: rtl/pwm_capture_sync_edge_det.sv
// Synchronizer for the async PWM input plus one delay flop
// giving the synchronized level and its rise/fall pulses.
module pwm_capture_sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] syncQ;
  logic              levelD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncQ  <= '0;
      levelD <= 1'b0;
    end else begin
      syncQ  <= {syncQ[STAGES-2:0], din};
      levelD <= syncQ[STAGES-1];
    end
  end

  assign level = syncQ[STAGES-1];
  assign rise  = level & ~levelD;
  assign fall  = ~level & levelD;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: reports high time and rise-to-rise period in clk
// cycles, with a timeout report for flat or missing input.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int COUNT_W     = DEF_COUNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               pwm_in,
  output logic [COUNT_W-1:0] duty_cnt,
  output logic [COUNT_W-1:0] period_cnt,
  output logic               meas_valid,
  output logic               timeout,
  output logic               pwm_level
);

  localparam logic [COUNT_W-1:0] TMAX = COUNT_W'(TIMEOUT);
  localparam logic [COUNT_W-1:0] ONE  = COUNT_W'(1);

  cap_state_t         state;
  logic [COUNT_W-1:0] hiCnt;
  logic [COUNT_W-1:0] perCnt;
  logic [COUNT_W-1:0] idleCnt;
  logic               level;
  logic               rise;
  logic               fall;

  function automatic logic [COUNT_W-1:0] satInc(
    input logic [COUNT_W-1:0] v
  );
    return (v == '1) ? v : v + ONE;
  endfunction

  pwm_capture_sync_edge_det #(
    .STAGES(SYNC_STAGES)
  ) uSync (
    .clk  (clk),
    .reset(reset),
    .din  (pwm_in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  assign pwm_level = level;

  // Edges outrank the timeout test, so P == TIMEOUT is a normal report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARM;
      hiCnt      <= '0;
      perCnt     <= '0;
      idleCnt    <= '0;
      duty_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        state   <= ARM;
        hiCnt   <= '0;
        perCnt  <= '0;
        idleCnt <= '0;
      end else begin
        unique case (state)
          ARM: begin
            if (rise) begin
              state   <= HIGH;
              hiCnt   <= ONE;
              perCnt  <= ONE;
              idleCnt <= '0;
            end else if (idleCnt == TMAX) begin
              duty_cnt   <= level ? TMAX : '0;
              period_cnt <= TMAX;
              timeout    <= 1'b1;
              meas_valid <= 1'b1;
              idleCnt    <= '0;
            end else begin
              idleCnt <= satInc(idleCnt);
            end
          end
          HIGH: begin
            if (fall) begin
              state  <= LOW;
              perCnt <= satInc(perCnt);
            end else if (perCnt == TMAX) begin
              duty_cnt   <= TMAX;
              period_cnt <= TMAX;
              timeout    <= 1'b1;
              meas_valid <= 1'b1;
              state      <= ARM;
              hiCnt      <= '0;
              perCnt     <= '0;
              idleCnt    <= '0;
            end else begin
              hiCnt  <= satInc(hiCnt);
              perCnt <= satInc(perCnt);
            end
          end
          LOW: begin
            if (rise) begin
              duty_cnt   <= hiCnt;
              period_cnt <= perCnt;
              timeout    <= 1'b0;
              meas_valid <= 1'b1;
              state      <= HIGH;
              hiCnt      <= ONE;
              perCnt     <= ONE;
            end else if (perCnt == TMAX) begin
              duty_cnt   <= '0;
              period_cnt <= TMAX;
              timeout    <= 1'b1;
              meas_valid <= 1'b1;
              state      <= ARM;
              hiCnt      <= '0;
              perCnt     <= '0;
              idleCnt    <= '0;
            end else begin
              perCnt <= satInc(perCnt);
            end
          end
          default: begin
            state <= ARM;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: periodic streams, reset,
// enable gating and timeout boundaries with TIMEOUT=1000.
module tb_pwm_capture;

  localparam int CW = 17;
  localparam int TO = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          pwm_in;
  logic [CW-1:0] duty_cnt;
  logic [CW-1:0] period_cnt;
  logic          meas_valid;
  logic          timeout;
  logic          pwm_level;

  typedef struct {
    int cyc;
    int duty;
    int per;
    int to;
  } rep_t;

  rep_t reps[$];
  int   cyc = 0;
  int   nChecks = 0;
  int   nPass = 0;

  pwm_capture #(
    .COUNT_W    (CW),
    .SYNC_STAGES(2),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .duty_cnt  (duty_cnt),
    .period_cnt(period_cnt),
    .meas_valid(meas_valid),
    .timeout   (timeout),
    .pwm_level (pwm_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (meas_valid) begin
      rep_t r;
      r.cyc  = cyc;
      r.duty = int'(duty_cnt);
      r.per  = int'(period_cnt);
      r.to   = int'(timeout);
      reps.push_back(r);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    nChecks++;
    if (got == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chkRep(input string tag, input int idx,
                        input int d, input int p, input int t);
    if (idx >= reps.size()) begin
      chk({tag, ".present"}, reps.size(), idx + 1);
    end else begin
      chk({tag, ".duty"}, reps[idx].duty, d);
      chk({tag, ".period"}, reps[idx].per, p);
      chk({tag, ".timeout"}, reps[idx].to, t);
    end
  endtask

  function automatic int gap(input int idx);
    if (idx >= reps.size() || idx < 1) return -1;
    return reps[idx].cyc - reps[idx-1].cyc;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drivePwm(input int h, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      tick(h);
      pwm_in = 1'b0;
      tick(p - h);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    reps.delete();
    tick(5);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    pwm_in = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(5);
    reps.delete();

    // periodic H=30 P=100
    drivePwm(30, 100, 4);
    chk("t2.count", reps.size(), 3);
    chkRep("t2.r0", 0, 30, 100, 0);
    chkRep("t2.r2", 2, 30, 100, 0);
    chk("t2.gap1", gap(1), 100);
    chk("t2.gap2", gap(2), 100);

    // reset mid-stream while high
    pwm_in = 1'b1;
    tick(10);
    chk("t1.preLevel", int'(pwm_level), 1);
    chk("t1.preDuty", int'(duty_cnt), 30);
    #2 reset = 1'b1;
    #1;
    chk("t1.rstDuty", int'(duty_cnt), 0);
    chk("t1.rstPeriod", int'(period_cnt), 0);
    chk("t1.rstValid", int'(meas_valid), 0);
    chk("t1.rstTimeout", int'(timeout), 0);
    chk("t1.rstLevel", int'(pwm_level), 0);
    pwm_in = 1'b0;
    tick(3);
    reset = 1'b0;
    reps.delete();
    tick(5);
    drivePwm(30, 100, 1);
    chk("t1.noRepOneRise", reps.size(), 0);
    drivePwm(30, 100, 1);
    chk("t1.countAfter2", reps.size(), 1);
    chkRep("t1.first", 0, 30, 100, 0);

    // flat low: idle timeout repeats
    doReset();
    tick(2100);
    chk("t3.count", reps.size(), 2);
    chkRep("t3.r0", 0, 0, TO, 1);
    chkRep("t3.r1", 1, 0, TO, 1);
    chk("t3.gap", gap(1), TO + 1);

    // flat high after one rise, then a real period
    doReset();
    pwm_in = 1'b1;
    tick(1100);
    chk("t4.count", reps.size(), 1);
    chkRep("t4.hi", 0, TO, TO, 1);
    pwm_in = 1'b0;
    tick(50);
    drivePwm(20, 60, 2);
    chk("t4.count2", reps.size(), 2);
    chkRep("t4.real", 1, 20, 60, 0);

    // enable dropped mid-high of H=64 P=256
    doReset();
    drivePwm(64, 256, 3);
    pwm_in = 1'b1;
    tick(20);
    chk("t5.preCount", reps.size(), 3);
    chkRep("t5.pre", 2, 64, 256, 0);
    enable = 1'b0;
    tick(44);
    pwm_in = 1'b0;
    tick(192);
    pwm_in = 1'b1;
    tick(64);
    pwm_in = 1'b0;
    tick(100);
    chk("t5.noStrobe", reps.size(), 3);
    chk("t5.holdDuty", int'(duty_cnt), 64);
    chk("t5.holdPeriod", int'(period_cnt), 256);
    chk("t5.holdTimeout", int'(timeout), 0);
    chk("t5.levelTracks", int'(pwm_level), 0);
    enable = 1'b1;
    tick(92);
    drivePwm(64, 256, 1);
    chk("t5.noRepFirstRise", reps.size(), 3);
    drivePwm(64, 256, 2);
    chk("t5.postCount", reps.size(), 5);
    chkRep("t5.re0", 3, 64, 256, 0);
    chkRep("t5.re1", 4, 64, 256, 0);

    // P == TIMEOUT is normal; P == TIMEOUT+1 times out
    doReset();
    drivePwm(100, TO, 3);
    chk("t6.count", reps.size(), 2);
    chkRep("t6.r0", 0, 100, TO, 0);
    chkRep("t6.r1", 1, 100, TO, 0);
    drivePwm(100, TO + 1, 1);
    tick(10);
    chk("t6.count2", reps.size(), 4);
    chkRep("t6.r2", 2, 100, TO, 0);
    chkRep("t6.over", 3, 0, TO, 1);
    pwm_in = 1'b1;
    tick(20);
    chk("t6.armNoRep", reps.size(), 4);

    tick(5);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
